bcd_digit_counter: RTL and testbench
====================================

// Module: bcd_digit_counter
// PURPOSE
//  Prescaled single-digit BCD (decade) counter, up/down, with synchronous load.
//  Directly upstream of the per-segment 7-segment decoders: drives their in1..in4
//  digit inputs as out1..out4 (out1 = MSB).
//  Only codes 0-9 are ever driven, so decoder don't-care codes 10-15 never occur.
//  Carry/borrow pulses let several digits cascade into multi-digit displays.
// PARAMETERS
//  DIV        10  clock cycles per count step while en=1; legal range 1..65535
//  RESET_VAL   0  digit value after reset; legal range 0..9
// PORTS
//  clk       in   1  single clock, all state on rising edge
//  rst       in   1  synchronous reset, active-high
//  en        in   1  count enable; 0 freezes digit and prescaler
//  up        in   1  1 = count up, 0 = count down; sampled on the step cycle
//  load      in   1  synchronous load strobe
//  load_val  in   4  digit to load; must be 0..9
//  out1      out  1  digit bit 3 (MSB), to decoder in1
//  out2      out  1  digit bit 2, to decoder in2
//  out3      out  1  digit bit 1, to decoder in3
//  out4      out  1  digit bit 0 (LSB), to decoder in4
//  carry     out  1  1-cycle pulse on 9->0 wrap while counting up
//  borrow    out  1  1-cycle pulse on 0->9 wrap while counting down
//  step      out  1  1-cycle pulse on every cycle the digit advances
//  load_err  out  1  1-cycle pulse when load is given with load_val > 9
// BEHAVIOUR
//  Reset (rst=1 at edge): digit=RESET_VAL, prescaler=0, carry=borrow=step=load_err=0.
//   rst overrides load and en in the same cycle. Reset mid-count discards the
//   prescaler phase.
//  Prescaler: counts 0..DIV-1 while en=1.
//   A step fires on the edge where the prescaler equals DIV-1 and en=1; the
//   prescaler then returns to 0.
//   Prescaler width is clog2(DIV), minimum 1 bit. With DIV=1, a step fires on
//   every en=1 cycle.
//  Step, up=1: digit+1; 9 -> 0 with carry=1 for that cycle.
//  Step, up=0: digit-1; 0 -> 9 with borrow=1 for that cycle.
//  Latency: out1..out4, carry, borrow and step are registered. They change on the
//   same edge that performs the step.
//  Load priority: load=1 beats a pending step.
//   - load_val 0..9: digit=load_val, prescaler=0. No step/carry/borrow that cycle.
//   - load_val 10..15: digit and prescaler unchanged (no step fires that cycle),
//     load_err=1 for one cycle.
//   - load acts regardless of en.
//  Invariant: the digit is always 0..9 (checked by assertion in the bench).
//  Pulse outputs are low on every cycle not listed above. carry and borrow are
//   never high together.
// TESTING
//  1. DIV=1, RESET_VAL=0: rst, then en=1 up=1 for 12 cycles -> digit 1..9,0,1,2;
//     carry high only on the 9->0 edge.
//  2. DIV=4: en=1 up=0 from 0 -> digit changes every 4th cycle: 9,8,7...;
//     borrow on the first step.
//  3. load=1 load_val=7 on the step-due cycle -> digit=7, step=0, prescaler
//     restarts; next step 4 cycles later to 8.
//  4. load=1 load_val=12 with digit=3 -> digit stays 3, load_err=1 one cycle;
//     prescaler phase preserved.
//  5. en=0 for 20 cycles mid-count -> outputs frozen; counting resumes with the
//     prior prescaler phase.
//  6. rst=1 together with load=1 load_val=5, RESET_VAL=2 -> digit=2, all pulse
//     outputs 0.

Source files
------------

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - prescaled single-digit BCD up/down counter with synchronous load
module bcd_digit_counter #(
    parameter int DIV       = 10,
    parameter int RESET_VAL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       out1,
    output logic       out2,
    output logic       out3,
    output logic       out4,
    output logic       carry,
    output logic       borrow,
    output logic       step,
    output logic       load_err
);

    // Prescaler needs at least one bit even when DIV=1 (it then sits at 0 and
    // every enabled cycle is a step cycle).
    localparam int             PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX   = PW'(DIV - 1);
    localparam logic [PW-1:0]  PRE_ONE   = PW'(1);
    localparam logic [3:0]     RST_DIGIT = 4'(RESET_VAL);

    logic [3:0]    digit_q,    digit_d;
    logic [PW-1:0] pre_q,      pre_d;
    logic          carry_q,    carry_d;
    logic          borrow_q,   borrow_d;
    logic          step_q,     step_d;
    logic          load_err_q, load_err_d;

    // Next-state: load (valid or not) pre-empts stepping; otherwise the
    // prescaler advances while enabled and the digit moves when it wraps.
    always_comb begin
        digit_d    = digit_q;
        pre_d      = pre_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        step_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_val <= 4'd9) begin
                digit_d = load_val;
                pre_d   = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (pre_q == PRE_MAX) begin
                pre_d  = '0;
                step_d = 1'b1;
                if (up) begin
                    if (digit_q == 4'd9) begin
                        digit_d = 4'd0;
                        carry_d = 1'b1;
                    end else begin
                        digit_d = digit_q + 4'd1;
                    end
                end else begin
                    if (digit_q == 4'd0) begin
                        digit_d  = 4'd9;
                        borrow_d = 1'b1;
                    end else begin
                        digit_d = digit_q - 4'd1;
                    end
                end
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end
    end

    // State and pulse registers; reset discards any prescaler phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q    <= RST_DIGIT;
            pre_q      <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            step_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            digit_q    <= digit_d;
            pre_q      <= pre_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            step_q     <= step_d;
            load_err_q <= load_err_d;
        end
    end

    assign out1     = digit_q[3];
    assign out2     = digit_q[2];
    assign out3     = digit_q[1];
    assign out4     = digit_q[0];
    assign carry    = carry_q;
    assign borrow   = borrow_q;
    assign step     = step_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// tb/tb_bcd_digit_counter.sv - directed table-driven bench for bcd_digit_counter
module tb_bcd_digit_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic a_o1, a_o2, a_o3, a_o4, a_c, a_b, a_s, a_e;
    logic b_o1, b_o2, b_o3, b_o4, b_c, b_b, b_s, b_e;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    // Instance A: DIV=1, RESET_VAL=0
    bcd_digit_counter #(.DIV(1), .RESET_VAL(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .out1(a_o1), .out2(a_o2), .out3(a_o3), .out4(a_o4),
        .carry(a_c), .borrow(a_b), .step(a_s), .load_err(a_e)
    );

    // Instance B: DIV=4, RESET_VAL=2
    bcd_digit_counter #(.DIV(4), .RESET_VAL(2)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .out1(b_o1), .out2(b_o2), .out3(b_o3), .out4(b_o4),
        .carry(b_c), .borrow(b_b), .step(b_s), .load_err(b_e)
    );

    wire [3:0] a_digit = {a_o1, a_o2, a_o3, a_o4};
    wire [3:0] b_digit = {b_o1, b_o2, b_o3, b_o4};

    typedef struct {
        logic       rst, en, up, load;
        logic [3:0] lv;
        logic [3:0] d;
        logic       c, b, s, e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic e_n, logic u, logic l, logic [3:0] lv,
                                logic [3:0] d, logic c, logic b, logic s, logic er);
        vec_t v;
        v.rst = r; v.en = e_n; v.up = u; v.load = l; v.lv = lv;
        v.d = d; v.c = c; v.b = b; v.s = s; v.e = er;
        return v;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got digit=%0d c/b/s/e=%b required digit=%0d c/b/s/e=%b",
                     name, act[7:4], act[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic drive(logic r, logic e_n, logic u, logic l, logic [3:0] lv);
        rst = r; en = e_n; up = u; load = l; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    // Invariants checked every cycle on both instances.
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (a_digit > 4'd9 || b_digit > 4'd9) begin
                errors++;
                $display("FAIL digit_range: got a=%0d b=%0d required <=9", a_digit, b_digit);
            end
            checks++;
            if ((a_c && a_b) || (b_c && b_b)) begin
                errors++;
                $display("FAIL carry_borrow_excl: got a=%b%b b=%b%b required not both", a_c, a_b, b_c, b_b);
            end
        end
    end

    initial begin
        logic [3:0] exp_a [12];
        exp_a = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

        // Test 1 on instance A (DIV=1): reset then count up 12 cycles.
        drive(1, 0, 0, 0, 4'd0);
        started = 1'b1;
        check("a_reset", {a_digit, a_c, a_b, a_s, a_e}, {4'd0, 4'b0000});
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 1, 0, 4'd0);
            check($sformatf("a_up%0d", i), {a_digit, a_c, a_b, a_s, a_e},
                  {exp_a[i], (i == 9) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0});
        end

        // Instance B (DIV=4, RESET_VAL=2) vectors: rst en up load lv | d c b s e
        tbl.push_back(mk(1,1,1,1,4'd5,  4'd2,0,0,0,0)); // rst beats load
        tbl.push_back(mk(1,0,0,0,4'd0,  4'd2,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,4'd0,  4'd0,0,0,0,0)); // load 0
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd0,0,0,0,0)); // count down
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd9,0,1,1,0)); // 0->9 borrow
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd9,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd9,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd9,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd8,0,0,1,0));
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd8,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd8,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd8,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,4'd0,  4'd7,0,0,1,0));
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd7,0,0,0,0)); // switch to up
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd7,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd7,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,4'd7,  4'd7,0,0,0,0)); // load on step-due cycle
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd7,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd7,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd7,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd8,0,0,1,0)); // 4 cycles later
        tbl.push_back(mk(0,1,1,1,4'd3,  4'd3,0,0,0,0)); // load 3
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd3,0,0,0,0)); // phase 1
        tbl.push_back(mk(0,1,1,1,4'd12, 4'd3,0,0,0,1)); // bad load, phase kept
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd3,0,0,0,0)); // phase 2
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd3,0,0,0,0)); // phase 3
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd4,0,0,1,0)); // step
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd4,0,0,0,0)); // phase 1
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd4,0,0,0,0)); // phase 2
        tbl.push_back(mk(0,0,1,1,4'd9,  4'd9,0,0,0,0)); // load while en=0
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd9,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd9,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd9,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd0,1,0,1,0)); // 9->0 carry
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd0,0,0,0,0)); // phase 1
        tbl.push_back(mk(0,1,1,0,4'd0,  4'd0,0,0,0,0)); // phase 2

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].lv);
            check($sformatf("b_vec%0d", i), {b_digit, b_c, b_b, b_s, b_e},
                  {tbl[i].d, tbl[i].c, tbl[i].b, tbl[i].s, tbl[i].e});
        end

        // Test 5: freeze 20 cycles at phase 2, then resume with same phase.
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 0, 4'd0);
            check($sformatf("b_freeze%0d", i), {b_digit, b_c, b_b, b_s, b_e}, {4'd0, 4'b0000});
        end
        drive(0, 1, 1, 0, 4'd0);
        check("b_resume_p3", {b_digit, b_c, b_b, b_s, b_e}, {4'd0, 4'b0000});
        drive(0, 1, 1, 0, 4'd0);
        check("b_resume_step", {b_digit, b_c, b_b, b_s, b_e}, {4'd1, 4'b0010});

        // Reset mid-count discards phase: after reset, step needs 4 enabled cycles.
        drive(0, 1, 1, 0, 4'd0);
        drive(1, 1, 1, 0, 4'd0);
        check("b_midreset", {b_digit, b_c, b_b, b_s, b_e}, {4'd2, 4'b0000});
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 4'd0);
            check($sformatf("b_postrst%0d", i), {b_digit, b_c, b_b, b_s, b_e}, {4'd2, 4'b0000});
        end
        drive(0, 1, 1, 0, 4'd0);
        check("b_postrst_step", {b_digit, b_c, b_b, b_s, b_e}, {4'd3, 4'b0010});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
